// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the register map, the STATUS bit layout and the transmitter state encoding.
package mmio_uart_tx_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;

  localparam int STAT_FULL     = 0;
  localparam int STAT_EMPTY    = 1;
  localparam int STAT_BUSY     = 2;
  localparam int STAT_COUNT_LO = 3;
  localparam int STAT_COUNT_HI = 5;
  localparam int STAT_OVF      = 6;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
// A push is accepted only when not full and a pop only when not empty, both judged on registered state.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA store feeds a 4-deep FIFO, STATUS read reports it.
// Bus handshake: a store is a single-cycle we pulse with a selected address; no ready, never stalls.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx,
  output logic        busy
);

  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

  logic       sel;
  logic [1:0] off;
  logic       push_req;
  logic       clr_ovf;
  logic       ovf;

  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic [2:0] fifo_count;
  logic       pop;

  tx_state_e  state, state_n;
  logic [15:0] baud, baud_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shreg, sh_n;
  logic        tx_n;
  logic        bit_end;

  logic unused_bits;
  assign unused_bits = ^{a[1:0], wd[31:8]};

  assign sel      = (a[31:4] == BASE_ADDR[31:4]);
  assign off      = a[3:2];
  assign push_req = we & sel & (off == OFF_TXDATA);
  assign clr_ovf  = we & sel & (off == OFF_STATUS);

  sync_fifo #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (wd[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset)                       ovf <= 1'b0;
    else if (clr_ovf)                ovf <= 1'b0;
    else if (push_req && fifo_full)  ovf <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= TX_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
      tx      <= tx_n;
    end
  end

  // Each bit period starts with BAUD_RELOAD and ends on the cycle the counter reads zero.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    sh_n    = shreg;
    pop     = 1'b0;
    bit_end = (baud == '0);
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_n    = fifo_dout;
          baud_n  = BAUD_RELOAD;
          bit_n   = '0;
          state_n = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          baud_n  = BAUD_RELOAD;
          state_n = TX_DATA;
        end else begin
          baud_n = baud - 16'd1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          baud_n = BAUD_RELOAD;
          sh_n   = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = TX_STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else begin
          baud_n = baud - 16'd1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_n    = fifo_dout;
            baud_n  = BAUD_RELOAD;
            bit_n   = '0;
            state_n = TX_START;
          end else begin
            state_n = TX_IDLE;
          end
        end else begin
          baud_n = baud - 16'd1;
        end
      end
      default: state_n = TX_IDLE;
    endcase

    case (state_n)
      TX_START: tx_n = 1'b0;
      TX_DATA:  tx_n = sh_n[0];
      default:  tx_n = 1'b1;
    endcase
  end

  assign busy = (state != TX_IDLE);

  always_comb begin
    rd = '0;
    if (sel && off == OFF_STATUS) begin
      rd[STAT_FULL]                     = fifo_full;
      rd[STAT_EMPTY]                    = fifo_empty;
      rd[STAT_BUSY]                     = busy;
      rd[STAT_COUNT_HI:STAT_COUNT_LO]   = fifo_count;
      rd[STAT_OVF]                      = ovf;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4 and BASE_ADDR=0x400.
// Inputs change 1 ns after the rising edge; a negedge serial decoder checks frames against exp_q.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        tx;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  mmio_uart_tx #(
    .BASE_ADDR    (32'h0000_0400),
    .CLKS_PER_BIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1;
    a  = addr;
    wd = data;
    tick();
    we = 1'b0;
    a  = 32'h0;
    wd = 32'h0;
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] val);
    we = 1'b0;
    a  = addr;
    #1;
    val = rd;
    a  = 32'h0;
  endtask

  int last_run = 0;
  int run_len  = 0;

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    check("idle_reached", {63'h0, busy}, 64'h0);
    tick();
  endtask

  // Busy run-length recorder: last_run holds the length of the most recent busy burst.
  always @(negedge clk) begin
    if (busy === 1'b1) run_len++;
    else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  // Serial decoder: 4 samples per bit, data sampled mid-bit.
  bit         rx_active = 1'b0;
  int         rx_cnt    = 0;
  logic [7:0] rx_byte   = 8'h00;
  logic [7:0] rx_exp;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      rx_active = 1'b0;
      rx_cnt    = 0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 1;
      end
    end else begin
      if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2)
        rx_byte[(rx_cnt - 6) / 4] = tx;
      if (rx_cnt == 38) begin
        check("stop_bit", {63'h0, tx}, 64'h1);
        check("rx_expected_pending", {63'h0, exp_q.size() > 0}, 64'h1);
        if (exp_q.size() > 0) begin
          rx_exp = exp_q.pop_front();
          check("rx_byte", {56'h0, rx_byte}, {56'h0, rx_exp});
        end
        rx_active = 1'b0;
      end
      rx_cnt++;
    end
  end

  logic [31:0] val;
  logic [39:0] wave;
  logic [39:0] exp_wave;
  logic [7:0]  d;
  int          busy_cnt;
  int          low_cnt;

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    a     = 32'h0;
    wd    = 32'h0;
    tick();
    read_reg(32'h404, val);
    check("reset_status", {32'h0, val}, 64'h2);
    check("reset_tx", {63'h0, tx}, 64'h1);
    check("reset_busy", {63'h0, busy}, 64'h0);
    tick();
    reset = 1'b0;

    // Single frame 0x55: exact waveform and busy length
    d = 8'h55;
    exp_q.push_back(d);
    store(32'h400, {24'h0, d});
    check("lat_pre_tx", {63'h0, tx}, 64'h1);
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      wave[k] = tx;
      if (busy === 1'b1) busy_cnt++;
      if (k < 4)       exp_wave[k] = 1'b0;
      else if (k < 36) exp_wave[k] = d[(k - 4) / 4];
      else             exp_wave[k] = 1'b1;
    end
    check("frame_wave", {24'h0, wave}, {24'h0, exp_wave});
    check("frame_busy_cycles", 64'(busy_cnt), 64'd40);
    tick();
    check("frame_done_busy", {63'h0, busy}, 64'h0);
    check("frame_done_tx", {63'h0, tx}, 64'h1);
    tick();
    check("frame_busy_run", 64'(last_run), 64'd40);

    // Six back-to-back stores: 0x06 overflows, five gapless frames
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 6; i++) store(32'h400, 32'(i));
    read_reg(32'h404, val);
    check("ovf_status", {32'h0, val}, 64'h65);
    store(32'h408, 32'hFFFF_FFFF);
    read_reg(32'h404, val);
    check("ovf_kept_by_off2", {32'h0, val}, 64'h65);
    store(32'h404, 32'h0);
    read_reg(32'h404, val);
    check("ovf_cleared", {32'h0, val}, 64'h25);
    wait_idle(400);
    check("b2b_busy_run", 64'(last_run), 64'd200);
    read_reg(32'h404, val);
    check("b2b_idle_status", {32'h0, val}, 64'h2);

    // Two stores queued while a frame is in flight
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    store(32'h400, 32'hA5);
    repeat (3) tick();
    store(32'h400, 32'h5A);
    store(32'h400, 32'hC3);
    read_reg(32'h404, val);
    check("queued_status", {32'h0, val}, 64'h14);
    wait_idle(300);
    check("queued_busy_run", 64'(last_run), 64'd120);

    // Reset at frame cycle 15 with bytes queued and a store in the reset cycle
    store(32'h400, 32'h3C);
    tick();
    check("abort_start_tx", {63'h0, tx}, 64'h0);
    store(32'h400, 32'h11);
    store(32'h400, 32'h22);
    repeat (12) tick();
    check("abort_midframe_busy", {63'h0, busy}, 64'h1);
    reset = 1'b1;
    we    = 1'b1;
    a     = 32'h400;
    wd    = 32'h99;
    tick();
    reset = 1'b0;
    we    = 1'b0;
    a     = 32'h0;
    wd    = 32'h0;
    check("abort_tx", {63'h0, tx}, 64'h1);
    check("abort_busy", {63'h0, busy}, 64'h0);
    read_reg(32'h404, val);
    check("abort_status", {32'h0, val}, 64'h2);
    low_cnt  = 0;
    busy_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (tx !== 1'b1)   low_cnt++;
      if (busy !== 1'b0) busy_cnt++;
    end
    check("abort_no_tx", 64'(low_cnt), 64'd0);
    check("abort_no_busy", 64'(busy_cnt), 64'd0);

    // Unselected and reserved-offset stores, zero reads
    store(32'h60, 32'h77);
    store(32'h408, 32'h12);
    store(32'h40C, 32'h34);
    low_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (tx !== 1'b1) low_cnt++;
    end
    check("unsel_no_tx", 64'(low_cnt), 64'd0);
    read_reg(32'h404, val);
    check("unsel_status", {32'h0, val}, 64'h2);
    read_reg(32'h60, val);
    check("read_unsel", {32'h0, val}, 64'h0);
    read_reg(32'h400, val);
    check("read_txdata", {32'h0, val}, 64'h0);
    read_reg(32'h408, val);
    check("read_off2", {32'h0, val}, 64'h0);
    read_reg(32'h14, val);
    check("read_alias", {32'h0, val}, 64'h0);

    tick();
    check("rx_leftover", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
